// File: rtl/mult_pkg.sv
// Shared widths and constants for the 16x16 Booth/Wallace multiplier datapath.
package mult_pkg;

  localparam int ADD_W      = 32;
  localparam int A_W        = 31;
  localparam int B_LSB      = 2;
  localparam int B_ZERO_LO  = 4;
  localparam int B_ZERO_HI  = 8;
  // Positions 2..29 need a group generate; bit 30's group carry would be the discarded carry-out.
  localparam int PFX_W      = A_W - B_LSB - 1;
  localparam int PFX_LEVELS = 5;

  typedef logic [ADD_W-1:0] sum_t;

  function automatic logic [A_W-1:B_LSB] maskZeroBits(input logic [A_W-1:B_LSB] rowB);
    logic [A_W-1:B_LSB] r;
    r            = rowB;
    r[B_ZERO_LO] = 1'b0;
    r[B_ZERO_HI] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/prefix_cell.sv
// Kogge-Stone black cell: merges a high (G,P) group with the adjacent low group.
module prefix_cell (
  input  logic gHi_i,
  input  logic pHi_i,
  input  logic gLo_i,
  input  logic pLo_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = gHi_i | (pHi_i & gLo_i);
  assign p_o = pHi_i & pLo_i;

endmodule

// File: rtl/adder_32_r.sv
// Registered final-stage adder of the multiplier: sums the two reduced rows with a
// Kogge-Stone prefix network and takes the MSB from the externally supplied sign.
module adder_32_r
  import mult_pkg::*;
(
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [A_W-1:0]       A,
  input  logic [A_W-1:B_LSB]   B,
  input  logic                 sign,
  output logic [ADD_W-1:0]     C
);

  logic [A_W-1:B_LSB]                 bMasked;
  logic [A_W-1:B_LSB]                 pBit;
  logic [PFX_W-1:0]                   gBit;
  logic [PFX_LEVELS:0][PFX_W-1:0]     gLvl;
  logic [PFX_LEVELS:0][PFX_W-1:0]     pLvl;
  logic [A_W-1:B_LSB]                 carryIn;
  logic                               unusedP;
  sum_t                               result_d;
  sum_t                               result_q;

  // Bits 4 and 8 of B are structurally zero, so those positions collapse to half-adder g/p.
  assign bMasked = maskZeroBits(B);
  assign pBit    = A[A_W-1:B_LSB] ^ bMasked;
  assign gBit    = A[A_W-2:B_LSB] & bMasked[A_W-2:B_LSB];

  assign gLvl[0] = gBit;
  assign pLvl[0] = pBit[A_W-2:B_LSB];

  // Level lvl combines spans of 2^lvl; positions whose span already reaches bit 2 only need G.
  genvar lvl, j;
  generate
    for (lvl = 0; lvl < PFX_LEVELS; lvl++) begin : gLevel
      localparam int D = 1 << lvl;
      for (j = 0; j < PFX_W; j++) begin : gPos
        if (j < D) begin : gPass
          assign gLvl[lvl+1][j] = gLvl[lvl][j];
          assign pLvl[lvl+1][j] = pLvl[lvl][j];
        end else if (j < 2 * D) begin : gGray
          assign gLvl[lvl+1][j] = gLvl[lvl][j] | (pLvl[lvl][j] & gLvl[lvl][j-D]);
          assign pLvl[lvl+1][j] = pLvl[lvl][j];
        end else begin : gBlack
          prefix_cell uCell (
            .gHi_i (gLvl[lvl][j]),
            .pHi_i (pLvl[lvl][j]),
            .gLo_i (gLvl[lvl][j-D]),
            .pLo_i (pLvl[lvl][j-D]),
            .g_o   (gLvl[lvl+1][j]),
            .p_o   (pLvl[lvl+1][j])
          );
        end
      end
    end
  endgenerate

  assign unusedP = ^pLvl[PFX_LEVELS];

  assign carryIn  = {gLvl[PFX_LEVELS], 1'b0};
  assign result_d = {sign, pBit ^ carryIn, A[B_LSB-1:0]};

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign C = result_q;

endmodule

// File: tb/tb_adder_32_r.sv
// Self-checking bench for adder_32_r: arithmetic reference model plus directed/random vectors.
module tb_adder_32_r;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [30:0] A;
  logic [30:2] B;
  logic        sign;
  logic [31:0] C;

  int          checks;
  int          failures;
  logic [31:0] modelC;
  logic        modelValid;

  adder_32_r dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .A         (A),
    .B         (B),
    .sign      (sign),
    .C         (C)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Reference: plain modular addition with B's structurally-zero bits dropped, MSB from sign.
  always @(posedge sys_clk) begin
    logic [31:0] bFull;
    logic [30:0] s;
    bFull = {1'b0, B, 2'b00} & ~32'h0000_0110;
    s     = A + bFull[30:0];
    if (!sys_rst_n) modelC <= 32'h0;
    else            modelC <= {sign, s};
    modelValid <= 1'b1;
  end

  always @(negedge sys_clk) begin
    if (modelValid) begin
      checks++;
      if (C !== modelC) begin
        failures++;
        $display("[TB] FAIL model t=%0t C=%h expected=%h", $time, C, modelC);
      end
    end
  end

  task automatic applyStimulus(input logic rstN, input logic [30:0] a,
                               input logic [31:0] bFull, input logic s);
    sys_rst_n = rstN;
    A         = a;
    B         = bFull[30:2];
    sign      = s;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expected);
    checks++;
    if (C !== expected) begin
      failures++;
      $display("[TB] FAIL %s C=%h expected=%h", name, C, expected);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  initial begin
    logic [31:0] aFull, bFull, sumFull, prevExp;
    checks     = 0;
    failures   = 0;
    modelValid = 1'b0;

    applyStimulus(1'b0, 31'h7FFF_FFFF, 32'h0001_2344, 1'b1);
    tick();
    checkOutput("reset0", 32'h0000_0000);
    tick();
    checkOutput("reset1", 32'h0000_0000);

    applyStimulus(1'b1, 31'h0000_0001, 32'h0, 1'b0);
    tick();
    checkOutput("trivial", 32'h0000_0001);

    applyStimulus(1'b1, 31'h7FFF_FFFF, 32'h0000_0004, 1'b1);
    tick();
    checkOutput("overflow", 32'h8000_0003);

    applyStimulus(1'b1, 31'h0, 32'h0000_0110, 1'b0);
    tick();
    checkOutput("ignored", 32'h0000_0000);

    applyStimulus(1'b1, 31'h0000_0114, 32'h7FFF_FEEC, 1'b1);
    tick();
    checkOutput("ripple", 32'h8000_0000);

    applyStimulus(1'b1, 31'h1234_5678, 32'h0000_0EEC, 1'b0);
    tick();
    checkOutput("mixed", 32'h1234_6564);

    applyStimulus(1'b0, 31'h1234_5678, 32'h0000_0EEC, 1'b0);
    tick();
    checkOutput("midreset", 32'h0000_0000);

    // Back-to-back random operands satisfying the correctness contract.
    prevExp = 32'h0;
    for (int i = 0; i < 120; i++) begin
      if (i > 0) checkOutput("random", prevExp);
      aFull   = $urandom;
      bFull   = $urandom & ~32'h0000_0113;
      sumFull = aFull + bFull;
      applyStimulus(1'b1, aFull[30:0], bFull, sumFull[31]);
      prevExp = sumFull;
      tick();
    end
    checkOutput("random", prevExp);

    applyStimulus(1'b1, 31'h0, 32'h0, 1'b0);
    tick();
    checkOutput("zero", 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
